// File: rtl/fir_iq_decim.sv
// fir_iq_decim
//   Symmetric odd-length I/Q FIR decimator for the RX IQ chain. Each channel keeps a
//   circular buffer of NTAPS samples. Because the filter is linear-phase, it needs only
//   M+1 = (NTAPS+1)/2 MAC cycles: the two samples that share a coefficient are pre-added
//   (folded) first. Only every DECIM-th accepted sample produces an output. The
//   coefficient table can be rewritten at run time.
//
//   Build option: define FIR_IQ_DECIM_SAT_EN to clamp the scaled result to the signed
//   WIDTH range. Without it, the low WIDTH bits are kept (two's-complement wrap).
//
//   Ports
//     adc_clk     sole clock
//     reset       synchronous, active-high
//     enable      1 = filter, 0 = bypass (decimate only, no filtering)
//     in_strobe   single-cycle input valid
//     in_data_i/q signed input sample, WIDTH bits
//     coef_wr     coefficient write strobe (any state)
//     coef_addr   coefficient index k (0 = outer tap, M = centre); values above M are ignored
//     coef_data   signed Q2.(COEFF-2) coefficient
//     out_strobe  one-cycle output valid
//     out_data_i/q signed output sample, WIDTH bits
//     busy        FSM not idle
//     overrun     sticky: an in_strobe arrived while busy and was dropped
module fir_iq_decim #(
  parameter  int WIDTH = 24,
  parameter  int COEFF = 18,
  parameter  int NTAPS = 17,
  parameter  int DECIM = 2,
  localparam int M     = (NTAPS - 1) / 2,
  localparam int AW    = $clog2(M + 1)
) (
  input  logic                    adc_clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    in_strobe,
  input  logic signed [WIDTH-1:0] in_data_i,
  input  logic signed [WIDTH-1:0] in_data_q,
  input  logic                    coef_wr,
  input  logic        [AW-1:0]    coef_addr,
  input  logic signed [COEFF-1:0] coef_data,
  output logic                    out_strobe,
  output logic signed [WIDTH-1:0] out_data_i,
  output logic signed [WIDTH-1:0] out_data_q,
  output logic                    busy,
  output logic                    overrun
);

  localparam int IW    = $clog2(NTAPS);
  localparam int PW    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PREW  = WIDTH + 1;
  localparam int PRODW = WIDTH + COEFF + 1;
  localparam int ACCW  = PRODW + AW;

  localparam logic [IW-1:0] PTR_LAST = IW'(NTAPS - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(DECIM - 1);
  localparam logic [AW-1:0] K_LAST   = AW'(M);

  localparam logic signed [COEFF-1:0] UNITY = {2'b01, {(COEFF-2){1'b0}}};
  // Half an output LSB, added before the shift: round half up.
  localparam logic signed [ACCW:0]    RND   = {{(ACCW+3-COEFF){1'b0}}, 1'b1, {(COEFF-3){1'b0}}};
`ifdef FIR_IQ_DECIM_SAT_EN
  localparam logic signed [ACCW:0]    OMAX  = {{(ACCW+2-WIDTH){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW:0]    OMIN  = {{(ACCW+2-WIDTH){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_MAC   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Circular buffer index, incremented modulo NTAPS.
  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
    logic [IW-1:0] r;
    if (idx == PTR_LAST) r = {IW{1'b0}};
    else                 r = idx + IW'(1);
    return r;
  endfunction

  // Circular buffer index, decremented modulo NTAPS.
  function automatic logic [IW-1:0] idx_dec(input logic [IW-1:0] idx);
    logic [IW-1:0] r;
    if (idx == {IW{1'b0}}) r = PTR_LAST;
    else                   r = idx - IW'(1);
    return r;
  endfunction

  // Round, drop the Q2 fraction bits, and reduce to the output width.
  function automatic logic signed [WIDTH-1:0] scale_out(input logic signed [ACCW-1:0] a);
    logic signed [ACCW:0]    r;
    logic signed [ACCW:0]    s;
    logic signed [WIDTH-1:0] y;
    r = {a[ACCW-1], a} + RND;
    s = r >>> (COEFF - 2);
`ifdef FIR_IQ_DECIM_SAT_EN
    if (s > OMAX)      y = OMAX[WIDTH-1:0];
    else if (s < OMIN) y = OMIN[WIDTH-1:0];
    else               y = s[WIDTH-1:0];
`else
    y = s[WIDTH-1:0];
`endif
    return y;
  endfunction

  state_t                  state_q, state_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           rd_new_q, rd_new_d;   // walks from newest sample backwards
  logic [IW-1:0]           rd_old_q, rd_old_d;   // walks from oldest sample forwards
  logic [AW-1:0]           k_q, k_d;
  logic                    dec_q, dec_d;         // accepted sample is the decimating one
  logic signed [WIDTH-1:0] samp_q [2], samp_d [2];
  logic signed [WIDTH-1:0] smp_buf_q [2][NTAPS], smp_buf_d [2][NTAPS];
  logic signed [COEFF-1:0] coef_q [M+1], coef_d [M+1];
  logic signed [ACCW-1:0]  acc_q [2], acc_d [2];
  logic                    out_stb_q, out_stb_d;
  logic signed [WIDTH-1:0] out_dat_q [2], out_dat_d [2];
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;

  logic signed [PREW-1:0]  pre_sum  [2];
  logic signed [PRODW-1:0] tap_prod [2];
  logic                    decim_now;
  logic [PW-1:0]           phase_nxt;

  assign out_strobe = out_stb_q;
  assign out_data_i = out_dat_q[0];
  assign out_data_q = out_dat_q[1];
  assign busy       = busy_q;
  assign overrun    = overrun_q;

  // Next-state, datapath and output computation.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    ptr_d     = ptr_q;
    rd_new_d  = rd_new_q;
    rd_old_d  = rd_old_q;
    k_d       = k_q;
    dec_d     = dec_q;
    samp_d    = samp_q;
    smp_buf_d = smp_buf_q;
    coef_d    = coef_q;
    acc_d     = acc_q;
    out_stb_d = 1'b0;
    out_dat_d = out_dat_q;
    overrun_d = overrun_q;

    decim_now = (phase_q == PH_LAST);
    if (decim_now) phase_nxt = {PW{1'b0}};
    else           phase_nxt = phase_q + PW'(1);

    // Folded tap: the centre tap (k == M) has no mirror partner.
    for (int c = 0; c < 2; c++) begin
      if (k_q == K_LAST) pre_sum[c] = PREW'(smp_buf_q[c][rd_new_q]);
      else               pre_sum[c] = PREW'(smp_buf_q[c][rd_new_q]) + PREW'(smp_buf_q[c][rd_old_q]);
      tap_prod[c] = PRODW'(pre_sum[c]) * PRODW'(coef_q[k_q]);
    end

    if (coef_wr && (coef_addr <= K_LAST)) coef_d[coef_addr] = coef_data;
    else                                  coef_d = coef_q;

    if (in_strobe && (state_q != S_IDLE)) overrun_d = 1'b1;
    else                                  overrun_d = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (in_strobe) begin
          phase_d = phase_nxt;
          if (enable) begin
            state_d   = S_LATCH;
            dec_d     = decim_now;
            samp_d[0] = in_data_i;
            samp_d[1] = in_data_q;
          end else if (decim_now) begin
            out_stb_d    = 1'b1;
            out_dat_d[0] = in_data_i;
            out_dat_d[1] = in_data_q;
          end else begin
            out_stb_d = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        for (int c = 0; c < 2; c++) begin
          smp_buf_d[c][ptr_q] = samp_q[c];
          acc_d[c]            = {ACCW{1'b0}};
        end
        ptr_d    = idx_inc(ptr_q);
        rd_new_d = ptr_q;             // the sample being written now is x[n]
        rd_old_d = idx_inc(ptr_q);    // oldest retained sample is x[n-(NTAPS-1)]
        k_d      = {AW{1'b0}};
        if (dec_q) state_d = S_MAC;
        else       state_d = S_IDLE;
      end
      S_MAC: begin
        for (int c = 0; c < 2; c++) begin
          acc_d[c] = acc_q[c] + ACCW'(tap_prod[c]);
        end
        rd_new_d = idx_dec(rd_new_q);
        rd_old_d = idx_inc(rd_old_q);
        k_d      = k_q + AW'(1);
        if (k_q == K_LAST) state_d = S_OUT;
        else               state_d = S_MAC;
      end
      S_OUT: begin
        for (int c = 0; c < 2; c++) begin
          out_dat_d[c] = scale_out(acc_q[c]);
        end
        out_stb_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State register with synchronous reset to the impulse table and empty buffers.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      phase_q   <= {PW{1'b0}};
      ptr_q     <= {IW{1'b0}};
      rd_new_q  <= {IW{1'b0}};
      rd_old_q  <= {IW{1'b0}};
      k_q       <= {AW{1'b0}};
      dec_q     <= 1'b0;
      out_stb_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        samp_q[c]    <= {WIDTH{1'b0}};
        acc_q[c]     <= {ACCW{1'b0}};
        out_dat_q[c] <= {WIDTH{1'b0}};
        for (int t = 0; t < NTAPS; t++) begin
          smp_buf_q[c][t] <= {WIDTH{1'b0}};
        end
      end
      for (int t = 0; t <= M; t++) begin
        coef_q[t] <= (t == M) ? UNITY : {COEFF{1'b0}};
      end
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ptr_q     <= ptr_d;
      rd_new_q  <= rd_new_d;
      rd_old_q  <= rd_old_d;
      k_q       <= k_d;
      dec_q     <= dec_d;
      out_stb_q <= out_stb_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      samp_q    <= samp_d;
      acc_q     <= acc_d;
      out_dat_q <= out_dat_d;
      smp_buf_q <= smp_buf_d;
      coef_q    <= coef_d;
    end
  end

endmodule

// File: tb/tb_fir_iq_decim.sv
// Self-checking bench for fir_iq_decim. The reference model is a direct-form
// (unfolded) convolution over a shift-history of accepted samples.
module tb_fir_iq_decim;

  localparam int WIDTH = 24;
  localparam int COEFF = 18;
  localparam int NTAPS = 17;
  localparam int DECIM = 2;
  localparam int M     = (NTAPS - 1) / 2;
  localparam int AW    = $clog2(M + 1);

  logic             adc_clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             in_strobe;
  logic [WIDTH-1:0] in_data_i;
  logic [WIDTH-1:0] in_data_q;
  logic             coef_wr;
  logic [AW-1:0]    coef_addr;
  logic [COEFF-1:0] coef_data;
  logic             out_strobe;
  logic [WIDTH-1:0] out_data_i;
  logic [WIDTH-1:0] out_data_q;
  logic             busy;
  logic             overrun;

  fir_iq_decim #(
    .WIDTH(WIDTH), .COEFF(COEFF), .NTAPS(NTAPS), .DECIM(DECIM)
  ) dut (
    .adc_clk   (adc_clk),
    .reset     (reset),
    .enable    (enable),
    .in_strobe (in_strobe),
    .in_data_i (in_data_i),
    .in_data_q (in_data_q),
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_strobe(out_strobe),
    .out_data_i(out_data_i),
    .out_data_q(out_data_q),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 adc_clk = ~adc_clk;

  int     n_cmp = 0;
  int     n_err = 0;
  longint coef_m [M+1];
  longint hist [2][NTAPS];
  int     ph_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int t = 0; t <= M; t++) coef_m[t] = (t == M) ? (longint'(1) << (COEFF - 2)) : 0;
    for (int j = 0; j < NTAPS; j++) begin
      hist[0][j] = 0;
      hist[1][j] = 0;
    end
    ph_m = 0;
  endfunction

  function automatic void push(input logic [WIDTH-1:0] di, input logic [WIDTH-1:0] dq);
    for (int j = NTAPS - 1; j > 0; j--) begin
      hist[0][j] = hist[0][j-1];
      hist[1][j] = hist[1][j-1];
    end
    hist[0][0] = longint'($signed(di));
    hist[1][0] = longint'($signed(dq));
  endfunction

  // y[n] = sum_j h[j]*x[n-j] with h symmetric, then round half up and rescale.
  function automatic logic [WIDTH-1:0] ref_out(input int ch);
    longint acc;
    longint r;
    longint lim;
    int     t;
    acc = 0;
    for (int j = 0; j < NTAPS; j++) begin
      t = (j <= M) ? j : (NTAPS - 1 - j);
      acc += coef_m[t] * hist[ch][j];
    end
    r = (acc + (longint'(1) << (COEFF - 3))) >>> (COEFF - 2);
`ifdef FIR_IQ_DECIM_SAT_EN
    lim = longint'(1) << (WIDTH - 1);
    if (r > lim - 1)   r = lim - 1;
    else if (r < -lim) r = -lim;
`else
    lim = 0;
`endif
    return r[WIDTH-1:0];
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_strobe = 1'b0; coef_wr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wcoef(input int addr, input logic [COEFF-1:0] val);
    coef_addr = AW'(addr); coef_data = val; coef_wr = 1'b1;
    tick();
    coef_wr = 1'b0;
    if (addr <= M) coef_m[addr] = longint'($signed(val));
  endtask

  task automatic watch(input int win, output int seen, output int at,
                       output logic [WIDTH-1:0] gi, output logic [WIDTH-1:0] gq,
                       output logic b0, output logic bm, output logic ba);
    seen = 0; at = -1; gi = '0; gq = '0; b0 = 1'b0; bm = 1'b0; ba = 1'b0;
    for (int j = 0; j < win; j++) begin
      if (out_strobe) begin
        seen++;
        if (at < 0) begin at = j; gi = out_data_i; gq = out_data_q; end
      end
      if (j == 0)     b0 = busy;
      if (j == M + 2) bm = busy;
      if (j == M + 3) ba = busy;
      tick();
    end
  endtask

  // One strobe, then observe win cycles starting the cycle after the strobe edge.
  task automatic send(input logic [WIDTH-1:0] di, input logic [WIDTH-1:0] dq,
                      input logic en, input int win);
    logic dec, b0, bm, ba;
    logic [WIDTH-1:0] ei, eq, gi, gq;
    int seen, at;
    dec  = (ph_m == DECIM - 1);
    ph_m = dec ? 0 : ph_m + 1;
    if (en) begin
      push(di, dq);
      ei = ref_out(0); eq = ref_out(1);
    end else begin
      ei = di; eq = dq;
    end
    enable = en; in_data_i = di; in_data_q = dq; in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    watch(win, seen, at, gi, gq, b0, bm, ba);
    check("ostb_count", seen, dec ? 1 : 0);
    if (dec) begin
      check("ostb_latency", at, en ? M + 3 : 0);
      check("out_i", gi, ei);
      check("out_q", gq, eq);
    end
    if (en) begin
      check("busy_first", b0, 1'b1);
      check("busy_last", bm, dec);
      check("busy_clear", ba, 1'b0);
    end else begin
      check("busy_bypass", b0, 1'b0);
    end
  endtask

  task automatic ramp();
    for (int i = 1; i <= 12; i++) begin
      send(WIDTH'(i), WIDTH'(-i), 1'b1, 15);
      if (i == 10) check("ramp_in10", out_data_i, 24'd2);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] a, b, ei, eq, gi, gq;
    logic b0, bm, ba;
    int seen, at;

    reset = 1'b1; enable = 1'b1; in_strobe = 1'b0; in_data_i = '0; in_data_q = '0;
    coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
    tick(); tick();
    reset = 1'b0;
    model_reset();
    tick();
    check("rst_ostb", out_strobe, 1'b0);
    check("rst_out_i", out_data_i, 24'd0);
    check("rst_out_q", out_data_q, 24'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);

    // Impulse table: output is the input delayed by M samples.
    ramp();

    // Flat coefficients, constant input: 1062.5 rounds up to 1063.
    do_reset();
    for (int t = 0; t <= M; t++) wcoef(t, 18'h01000);
    for (int i = 0; i < 20; i++) send(24'd1000, 24'd1000, 1'b1, 15);
    check("flat_1063", out_data_i, 24'd1063);

    // Near-2 centre gain on full scale input: saturates or wraps.
    do_reset();
    for (int t = 0; t <= M; t++) wcoef(t, (t == M) ? 18'h1FFFF : 18'h00000);
    for (int i = 0; i < 16; i++) send(24'h7FFFFF, 24'h800000, 1'b1, 15);
`ifdef FIR_IQ_DECIM_SAT_EN
    check("big_i", out_data_i, 24'h7FFFFF);
`else
    check("big_i", out_data_i, 24'hFFFF7E);
`endif

    // Bypass: decimate only, buffer untouched, then filtering resumes.
    do_reset();
    for (int i = 1; i <= 6; i++) send(WIDTH'(10 * i), WIDTH'(-10 * i), 1'b0, 6);
    for (int i = 0; i < 6; i++) send(WIDTH'($urandom), WIDTH'($urandom), 1'b1, 15);

    // Randomized coefficients (including out-of-range writes), data, enable and spacing.
    do_reset();
    for (int t = 0; t <= M; t++) wcoef(t, COEFF'($urandom));
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) wcoef(int'($urandom_range(0, 15)), COEFF'($urandom));
      send(WIDTH'($urandom), WIDTH'($urandom), ($urandom_range(0, 5) != 0),
           int'($urandom_range(M + 4, M + 8)));
    end

    // Overrun: second strobe 3 clk after a decimating strobe is dropped.
    while (ph_m != DECIM - 1) send(WIDTH'($urandom), WIDTH'($urandom), 1'b1, 15);
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    ph_m = 0;
    push(a, ~a);
    ei = ref_out(0); eq = ref_out(1);
    enable = 1'b1; in_data_i = a; in_data_q = ~a; in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    tick(); tick();
    in_data_i = b; in_data_q = ~b; in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    watch(20, seen, at, gi, gq, b0, bm, ba);
    check("ovr_count", seen, 1);
    check("ovr_latency", at, M);
    check("ovr_i", gi, ei);
    check("ovr_q", gq, eq);
    check("ovr_flag", overrun, 1'b1);
    send(WIDTH'($urandom), WIDTH'($urandom), 1'b1, 15);
    send(WIDTH'($urandom), WIDTH'($urandom), 1'b1, 15);
    check("ovr_sticky", overrun, 1'b1);

    // Reset in the middle of a MAC: no output, everything cleared.
    do_reset();
    send(24'd1, -24'sd1, 1'b1, 15);
    enable = 1'b1; in_data_i = 24'd2; in_data_q = -24'sd2; in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    seen = 0;
    for (int j = 0; j < 16; j++) begin
      if (j == 0) reset = 1'b1;
      if (j == 2) reset = 1'b0;
      if (out_strobe) seen++;
      tick();
    end
    model_reset();
    check("rstmid_ostb", seen, 0);
    check("rstmid_out_i", out_data_i, 24'd0);
    check("rstmid_out_q", out_data_q, 24'd0);
    check("rstmid_overrun", overrun, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    ramp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
